// File: rtl/tcdm_traffic_gen_pkg.sv
// Shared types and helpers for the TCDM traffic generator.
// Pure definitions: no state, no latency, no flow control.
package tcdm_traffic_gen_pkg;

  typedef enum logic [1:0] {
    UNIFORM  = 2'd0,
    LINEAR   = 2'd1,
    CONSTANT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LfsrPoly = 32'h80200003;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    int unsigned s;
    s = n % 32;
    return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] x);
    return (&x) ? x : x + 32'd1;
  endfunction

  // Encoding 3 is reserved and behaves as constant-address mode.
  function automatic mode_e to_mode(input logic [1:0] m);
    case (m)
      2'd0:    return UNIFORM;
      2'd1:    return LINEAR;
      default: return CONSTANT;
    endcase
  endfunction

endpackage

// File: rtl/tcdm_tg_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enable; a zero seed loads as 1.
// next_o is the value the register takes at the coming edge, so callers can act on it a cycle early.
module tcdm_tg_lfsr
  import tcdm_traffic_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] seed_i,
  output logic [31:0] next_o
);

  logic [31:0] state_q;

  always_comb begin
    next_o = state_q;
    if (load_i) begin
      next_o = (seed_i == 32'd0) ? 32'd1 : seed_i;
    end else if (en_i) begin
      next_o = {1'b0, state_q[31:1]} ^ (state_q[0] ? LfsrPoly : 32'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= 32'd1;
    end else begin
      state_q <= next_o;
    end
  end

endmodule

// File: rtl/tcdm_traffic_gen.sv
// TCDM initiator issuing random/linear/constant word accesses and collecting handshake statistics.
// All outputs registered; a request is held until gnt_i and its response is expected one cycle later.
module tcdm_traffic_gen
  import tcdm_traffic_gen_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned NumBanks    = 16,
  parameter int unsigned MemAddrBits = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [8:0]             p_req_i,
  input  logic [31:0]            num_cycles_i,
  input  logic [31:0]            seed_i,
  input  logic                   wr_en_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   req_o,
  output logic [AddrWidth-1:0]   add_o,
  output logic                   wen_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [DataWidth/8-1:0] be_o,
  input  logic                   gnt_i,
  input  logic                   vld_i,
  input  logic [DataWidth-1:0]   rdata_i,
  output logic [31:0]            req_cnt_o,
  output logic [31:0]            gnt_cnt_o,
  output logic [31:0]            wait_cnt_o,
  output logic [31:0]            sig_o
);

  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned IdxW     = BankBits + MemAddrBits;
  localparam int unsigned WOff     = $clog2(DataWidth / 8);

  state_e               state_q;
  mode_e                mode_q, mode_eff;
  logic [8:0]           p_req_q, p_eff;
  logic                 wr_en_q, wr_eff;
  logic [31:0]          cyc_q;
  logic [IdxW-1:0]      idx_q, idx_d, word_idx;
  logic [31:0]          lfsr_d;
  logic                 out_q, out_rd_q;
  logic                 starting, grant, free, run_next, hit, issue;
  logic [AddrWidth-1:0] add_d;
  logic [DataWidth-1:0] wdata_d;
  logic [31:0]          rdata32;

  tcdm_tg_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (starting),
    .en_i   ((state_q == RUN) || (state_q == DRAIN)),
    .seed_i (seed_i),
    .next_o (lfsr_d)
  );

  // Request fields are built from the LFSR value of the cycle in which req_o will be high.
  always_comb begin
    starting = (state_q == IDLE) && start_i;
    grant    = req_o && gnt_i;
    free     = !req_o || gnt_i;
    mode_eff = starting ? to_mode(mode_i) : mode_q;
    p_eff    = starting ? p_req_i : p_req_q;
    wr_eff   = starting ? wr_en_i : wr_en_q;

    if (starting) begin
      idx_d = seed_i[IdxW-1:0];
    end else if (grant && (mode_q == LINEAR)) begin
      idx_d = idx_q + 1'b1;
    end else begin
      idx_d = idx_q;
    end

    word_idx = (mode_eff == UNIFORM) ? lfsr_d[IdxW-1:0] : idx_d;
    add_d = '0;
    add_d[WOff +: IdxW] = word_idx;

    wdata_d = '0;
    for (int i = 0; i < int'(DataWidth); i++) begin
      wdata_d[i] = lfsr_d[i % 32];
    end

    run_next = starting ? (num_cycles_i != 32'd0)
                        : ((state_q == RUN) && (cyc_q != 32'd1));
    hit      = {1'b0, lfsr_d[7:0]} < p_eff;
    issue    = run_next && free && hit;
    rdata32  = 32'(rdata_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mode_q     <= UNIFORM;
      p_req_q    <= '0;
      wr_en_q    <= 1'b0;
      cyc_q      <= '0;
      idx_q      <= '0;
      out_q      <= 1'b0;
      out_rd_q   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      req_o      <= 1'b0;
      add_o      <= '0;
      wen_o      <= 1'b0;
      wdata_o    <= '0;
      be_o       <= '0;
      req_cnt_o  <= '0;
      gnt_cnt_o  <= '0;
      wait_cnt_o <= '0;
      sig_o      <= '0;
    end else begin
      done_o   <= 1'b0;
      idx_q    <= idx_d;
      out_q    <= grant;
      out_rd_q <= grant && !wen_o;

      // A held request is only ever released by its grant, never by the end of RUN.
      if (issue) begin
        req_o   <= 1'b1;
        add_o   <= add_d;
        wen_o   <= wr_eff && lfsr_d[8];
        wdata_o <= wdata_d;
        be_o    <= '1;
      end else if (grant) begin
        req_o   <= 1'b0;
      end

      if (starting) begin
        req_cnt_o  <= '0;
        gnt_cnt_o  <= '0;
        wait_cnt_o <= '0;
        sig_o      <= '0;
        err_o      <= 1'b0;
      end else begin
        if (grant) begin
          req_cnt_o <= sat_inc32(req_cnt_o);
          gnt_cnt_o <= sat_inc32(gnt_cnt_o);
        end
        if (req_o && !gnt_i) begin
          wait_cnt_o <= sat_inc32(wait_cnt_o);
        end
        if (vld_i != out_q) begin
          err_o <= 1'b1;
        end
        if (vld_i && out_rd_q) begin
          sig_o <= rotl32(sig_o, 1) ^ rdata32;
        end
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_eff;
            p_req_q <= p_req_i;
            wr_en_q <= wr_en_i;
            cyc_q   <= num_cycles_i;
            busy_o  <= 1'b1;
            state_q <= (num_cycles_i == 32'd0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          cyc_q <= cyc_q - 32'd1;
          if (cyc_q == 32'd1) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // A response due this cycle is settled this cycle, so only a held request blocks completion.
          if (!req_o) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcdm_traffic_gen.sv
// Directed bench for tcdm_traffic_gen: vector table with gnt tied high plus hand-written stall, drop and reset sequences.
module tb_tcdm_traffic_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [8:0]  p_req_i;
  logic [31:0] num_cycles_i;
  logic [31:0] seed_i;
  logic        wr_en_i;
  logic        busy_o, done_o, err_o, req_o, wen_o;
  logic [31:0] add_o, wdata_o, rdata_i;
  logic [3:0]  be_o;
  logic        gnt_i, vld_i;
  logic [31:0] req_cnt_o, gnt_cnt_o, wait_cnt_o, sig_o;

  tcdm_traffic_gen dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .p_req_i(p_req_i), .num_cycles_i(num_cycles_i), .seed_i(seed_i),
    .wr_en_i(wr_en_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o),
    .be_o(be_o), .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i),
    .req_cnt_o(req_cnt_o), .gnt_cnt_o(gnt_cnt_o), .wait_cnt_o(wait_cnt_o),
    .sig_o(sig_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  mode;
    logic [8:0]  p;
    int          n;
    logic [31:0] seed;
    bit          wr;
    int          exp_req;
    logic [31:0] add0;
    logic [31:0] addl;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] addr_log[$];
  int          done_seen, done_cyc, cyc_idx, stall_left;
  bit          resp_pend, drop_once;
  logic [31:0] resp_data;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'd0);
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  // Reference behaviour with every request granted in the cycle it is raised.
  task automatic model_run(input logic [1:0] mode, input logic [8:0] p, input int n,
                           input logic [31:0] seed, input bit wr, output int cnt,
                           output logic [31:0] sig, output logic [31:0] a0, output logic [31:0] al);
    logic [31:0] l, a;
    logic [15:0] idx, w;
    l = (seed == 32'd0) ? 32'd1 : seed;
    idx = seed[15:0];
    cnt = 0; sig = '0; a0 = '0; al = '0;
    for (int k = 0; k < n; k++) begin
      if ({1'b0, l[7:0]} < p) begin
        w = (mode == 2'd0) ? l[15:0] : idx;
        a = {14'd0, w, 2'b00};
        if (cnt == 0) a0 = a;
        al = a;
        if (!(wr && l[8])) sig = rotl1(sig) ^ hash(a);
        if (mode == 2'd1) idx = idx + 16'd1;
        cnt++;
      end
      l = lstep(l);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle: drive the responder at the falling edge and log what the DUT shows.
  task automatic step();
    @(negedge clk_i);
    cyc_idx++;
    vld_i = resp_pend && !drop_once;
    if (resp_pend && drop_once) drop_once = 1'b0;
    rdata_i = resp_data;
    if (req_o && stall_left > 0) begin
      gnt_i = 1'b0;
      stall_left--;
    end else begin
      gnt_i = 1'b1;
    end
    resp_pend = req_o && gnt_i;
    resp_data = hash(add_o);
    if (resp_pend) addr_log.push_back(add_o);
    if (done_o) begin
      done_seen++;
      done_cyc = cyc_idx;
    end
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [8:0] p, input int n,
                           input logic [31:0] seed, input bit wr);
    addr_log.delete();
    done_seen = 0; done_cyc = -1; cyc_idx = 0;
    mode_i = mode; p_req_i = p; num_cycles_i = n; seed_i = seed; wr_en_i = wr;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_seen == 0 && k < 600) begin
      step();
      k++;
    end
    if (done_seen == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_pulse", name);
    end
    step();
    step();
  endtask

  vec_t        vecs[9];
  int          m_cnt;
  logic [31:0] m_sig, m_a0, m_al;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; mode_i = '0; p_req_i = '0; num_cycles_i = '0;
    seed_i = '0; wr_en_i = 1'b0; gnt_i = 1'b0; vld_i = 1'b0; rdata_i = '0;
    resp_pend = 1'b0; resp_data = '0; drop_once = 1'b0; stall_left = 0;
    done_seen = 0; done_cyc = -1; cyc_idx = 0;

    repeat (2) @(negedge clk_i);
    chk("rst_req", {63'd0, req_o}, 64'd0);
    chk("rst_busy_done_err", {61'd0, busy_o, done_o, err_o}, 64'd0);
    chk("rst_fields", {wen_o, add_o, be_o}, 64'd0);
    chk("rst_wdata", {32'd0, wdata_o}, 64'd0);
    chk("rst_cnts", {req_cnt_o, wait_cnt_o}, 64'd0);
    chk("rst_gnt_sig", {gnt_cnt_o, sig_o}, 64'd0);
    rst_ni = 1'b1;
    step();

    vecs[0] = '{2'd1, 9'd256, 8,   32'h10,    1'b0, 8, 32'h40,    32'h5C};
    vecs[1] = '{2'd2, 9'd256, 5,   32'h123,   1'b0, 5, 32'h48C,   32'h48C};
    vecs[2] = '{2'd3, 9'd256, 3,   32'h5,     1'b0, 3, 32'h14,    32'h14};
    vecs[3] = '{2'd1, 9'd256, 4,   32'h7FFFE, 1'b0, 4, 32'h3FFF8, 32'h4};
    vecs[4] = '{2'd1, 9'd0,   100, 32'h10,    1'b0, 0, 32'h0,     32'h0};
    vecs[5] = '{2'd2, 9'd256, 0,   32'h10,    1'b0, 0, 32'h0,     32'h0};
    vecs[6] = '{2'd1, 9'd256, 6,   32'h40,    1'b1, 6, 32'h100,   32'h114};
    vecs[7] = '{2'd0, 9'd128, 30,  32'hACE1,  1'b1, 0, 32'h0,     32'h0};
    vecs[8] = '{2'd0, 9'd256, 5,   32'h0,     1'b0, 0, 32'h0,     32'h0};
    for (int v = 7; v <= 8; v++) begin
      model_run(vecs[v].mode, vecs[v].p, vecs[v].n, vecs[v].seed, vecs[v].wr, m_cnt, m_sig, m_a0, m_al);
      vecs[v].exp_req = m_cnt;
      vecs[v].add0 = m_a0;
      vecs[v].addl = m_al;
    end

    for (int v = 0; v < 9; v++) begin
      model_run(vecs[v].mode, vecs[v].p, vecs[v].n, vecs[v].seed, vecs[v].wr, m_cnt, m_sig, m_a0, m_al);
      start_run(vecs[v].mode, vecs[v].p, vecs[v].n, vecs[v].seed, vecs[v].wr);
      chk($sformatf("v%0d_busy_t1", v), {63'd0, busy_o}, 64'd1);
      wait_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_req_cnt", v), {32'd0, req_cnt_o}, 64'(vecs[v].exp_req));
      chk($sformatf("v%0d_gnt_cnt", v), {32'd0, gnt_cnt_o}, 64'(vecs[v].exp_req));
      chk($sformatf("v%0d_wait_cnt", v), {32'd0, wait_cnt_o}, 64'd0);
      chk($sformatf("v%0d_sig", v), {32'd0, sig_o}, {32'd0, m_sig});
      chk($sformatf("v%0d_err", v), {63'd0, err_o}, 64'd0);
      chk($sformatf("v%0d_done_pulses", v), 64'(done_seen), 64'd1);
      chk($sformatf("v%0d_done_cycle", v), 64'(done_cyc), 64'(vecs[v].n + 2));
      chk($sformatf("v%0d_num_grants", v), 64'(addr_log.size()), 64'(vecs[v].exp_req));
      if (addr_log.size() > 0) begin
        chk($sformatf("v%0d_first_add", v), {32'd0, addr_log[0]}, {32'd0, vecs[v].add0});
        chk($sformatf("v%0d_last_add", v), {32'd0, addr_log[addr_log.size()-1]}, {32'd0, vecs[v].addl});
      end
    end

    // Three stall cycles on the first request, then free-running grants.
    stall_left = 3;
    start_run(2'd2, 9'd256, 8, 32'h20, 1'b0);
    chk("stall_req_t1", {63'd0, req_o}, 64'd1);
    for (int k = 2; k <= 3; k++) begin
      step();
      chk($sformatf("stall_req_t%0d", k), {63'd0, req_o}, 64'd1);
      chk($sformatf("stall_add_t%0d", k), {32'd0, add_o}, 64'h80);
    end
    wait_done("stall3");
    chk("stall3_wait", {32'd0, wait_cnt_o}, 64'd3);
    chk("stall3_req", {32'd0, req_cnt_o}, 64'd5);
    chk("stall3_err", {63'd0, err_o}, 64'd0);

    // RUN ends while the only request is still stalled.
    stall_left = 6;
    start_run(2'd2, 9'd256, 2, 32'h20, 1'b0);
    repeat (3) step();
    chk("tail_held_req", {63'd0, req_o}, 64'd1);
    chk("tail_held_busy", {63'd0, busy_o}, 64'd1);
    wait_done("tail");
    chk("tail_req", {32'd0, req_cnt_o}, 64'd1);
    chk("tail_wait", {32'd0, wait_cnt_o}, 64'd6);
    chk("tail_err", {63'd0, err_o}, 64'd0);
    chk("tail_done", 64'(done_seen), 64'd1);

    // Dropped response: error is sticky until the next start.
    drop_once = 1'b1;
    start_run(2'd1, 9'd256, 4, 32'h0, 1'b0);
    wait_done("drop");
    chk("drop_err", {63'd0, err_o}, 64'd1);
    repeat (3) step();
    chk("drop_err_sticky", {63'd0, err_o}, 64'd1);
    start_run(2'd1, 9'd256, 2, 32'h0, 1'b0);
    chk("drop_err_cleared", {63'd0, err_o}, 64'd0);
    wait_done("drop_clean");
    chk("drop_clean_err", {63'd0, err_o}, 64'd0);

    // Uniform run repeated with the same seed.
    model_run(2'd0, 9'd200, 40, 32'hBEEF, 1'b0, m_cnt, m_sig, m_a0, m_al);
    for (int r = 0; r < 2; r++) begin
      start_run(2'd0, 9'd200, 40, 32'hBEEF, 1'b0);
      wait_done($sformatf("uni%0d", r));
      chk($sformatf("uni%0d_req", r), {32'd0, req_cnt_o}, 64'(m_cnt));
      chk($sformatf("uni%0d_sig", r), {32'd0, sig_o}, {32'd0, m_sig});
    end

    // Asynchronous reset in the middle of a run.
    start_run(2'd2, 9'd256, 50, 32'h33, 1'b0);
    repeat (3) step();
    chk("midrst_pre_req", {63'd0, req_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_req", {63'd0, req_o}, 64'd0);
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    chk("midrst_cnt", {32'd0, req_cnt_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
